// File: rtl/seven_seg_scan.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seven_seg_scan #(
  parameter int CLK_DIV    = 50000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       value,
  output logic [3:0]                    bcd,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]        r_cnt;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic                    r_pending;

  logic       w_tick;
  logic       w_last;
  logic       w_commit;
  logic       w_blank;
  logic [3:0] w_nib;

`ifdef LEADING_ZERO_BLANK_EN
  // Digit idx is blank when it and every more significant nibble are zero.
  function automatic logic f_blank(input logic [4*NUM_DIGITS-1:0] act,
                                   input logic [IDX_W-1:0]        idx);
    logic zero;
    zero = (idx != '0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(idx)) && (act[4*j +: 4] != 4'h0)) zero = 1'b0;
    end
    return zero;
  endfunction
`endif

  always_comb begin
    w_tick   = (r_cnt == CNT_W'(CLK_DIV - 1));
    w_last   = (digit_idx == IDX_W'(NUM_DIGITS - 1));
    w_commit = w_tick && w_last && r_pending;
    w_nib    = r_active[4*digit_idx +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    w_blank  = f_blank(r_active, digit_idx);
`else
    w_blank  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      digit_idx  <= '0;
      an         <= '1;
      bcd        <= 4'hF;
      frame_done <= 1'b0;
      r_shadow   <= '0;
      r_active   <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_cnt      <= w_tick ? '0 : r_cnt + 1'b1;
      frame_done <= w_tick && w_last;

      // Tick edge opens a one-cycle dead time before the next digit drives.
      if (w_tick) begin
        digit_idx <= w_last ? '0 : digit_idx + 1'b1;
        an        <= '1;
      end else if (r_cnt == '0) begin
        an  <= ~(NUM_DIGITS'(1) << digit_idx);
        bcd <= w_blank ? 4'hF : w_nib;
      end

      // Commit samples the old shadow; a coincident load stays pending.
      if (w_commit) r_active <= r_shadow;
      if (load) begin
        r_shadow  <= value;
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed scan controller for a NUM_DIGITS common-anode seven-segment display. Holds a packed BCD value and, on a prescaled refresh tick, steps through the digits one at a time. For each digit it presents one BCD nibble to the downstream BCD-to-seven-segment decoder and drives the matching active-low anode. New values are double-buffered and committed only at a frame boundary, so a displayed number never tears.

## Interface
- CLK_DIV, 50000, clock cycles per digit slot; legal range ≥ 2
- NUM_DIGITS, 4, number of digits scanned; legal range 2–8
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- load  input  1  one-cycle strobe; capture value into shadow register
- value  input  4*NUM_DIGITS  packed BCD; nibble i = digit i, nibble 0 = least significant
- bcd  output  4  nibble for the decoder; 4'hF = blank (decoder default → all segments off)
- an  output  NUM_DIGITS  anode enables, active-low, at most one low
- digit_idx  output  $clog2(NUM_DIGITS)  index of current digit slot
- frame_done  output  1  one-cycle pulse when scan wraps from last digit to digit 0

## Operation
- Prescaler cnt counts 0..CLK_DIV-1 and wraps. tick = (cnt == CLK_DIV-1).
- On a tick edge:
  - digit_idx advances and wraps from NUM_DIGITS-1 to 0.
  - an is forced to all ones (one-cycle dead time against ghosting).
- On an edge with cnt == 0:
  - an goes to ~(1 << digit_idx).
  - bcd goes to nibble digit_idx of the active register, or 4'hF if blanked.
- Nibbles > 9 are forwarded unchanged; the decoder blanks them.
- Load path:
  - load = 1 sets shadow <= value and pending <= 1.
  - Repeated loads before a commit: last one wins.
- Commit and frame_done:
  - On a tick edge where digit_idx == NUM_DIGITS-1, frame_done <= 1 for one cycle.
  - If pending == 1 on that edge, active <= shadow and pending <= 0.
- Simultaneous load and commit on the same edge:
  - Commit takes the old shadow.
  - shadow takes the new value.
  - pending stays 1, so the new value shows next frame.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Reset values (asynchronous, immediate): cnt = 0, digit_idx = 0, an = all ones, bcd = 4'hF, frame_done = 0, shadow = 0, active = 0, pending = 0.
- First rising edge after rst_n deasserts: an[0] low, bcd = active nibble 0 (0).
- Digit slot:
  - Length CLK_DIV cycles.
  - Anode low for CLK_DIV-1 cycles, dead for 1 cycle.
  - Frame = NUM_DIGITS*CLK_DIV cycles.
- Load-to-display latency:
  - Minimum: rest of the current frame, plus the commit edge, plus 1 cycle to reach digit 0.
  - Maximum: one full frame + 1 cycle.
- frame_done is high during the dead cycle of digit 0.
- rst_n asserted mid-scan: all state returns to reset values immediately, and any pending load is discarded.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digit i > 0 is blanked (bcd = 4'hF, anode still driven) when active nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - Blanking is evaluated on the active register, not on shadow.
- Undefined: every digit shows its nibble, including leading zeros.

## Test plan
- Reset, CLK_DIV = 4, NUM_DIGITS = 4, no load -> an = 4'b1111 and bcd = 4'hF during reset; first edge after release an = 4'b1110, bcd = 0; frame_done first pulses at cycle 16.
- load value = 16'h1234, then run two frames -> after commit, per slot (an, bcd) = (1110, 4), (1101, 3), (1011, 2), (0111, 1); 1 dead cycle of an = 1111 between slots.
- LEADING_ZERO_BLANK_EN with value = 16'h0042 -> bcd per slot 2, 4, F, F; with value = 16'h0000 -> 0, F, F, F. Without the macro, 16'h0042 -> 2, 4, 0, 0.
- load 16'h5678 at digit 1 mid-frame -> digits 1–3 of the current frame show the old value; 5678 appears from the digit-0 slot following frame_done.
- load 16'h1111 then 16'h2222 in the same frame, and a separate load asserted on the commit edge -> only 2222 is committed; the load on the commit edge appears one frame later.
- Assert rst_n low mid-slot at digit 2 with pending = 1 -> an = all ones and bcd = F immediately; after release the scan restarts at digit 0 showing 0, and the pending value never appears.
